// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues one SRAM request at a time, holds the
// fetched word for the IF/ID register, and handles stalls, branches and
// exception flushes, including flushes that land on an outstanding fetch.
module if_fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic [3:0]  stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        jump_flag,
  input  logic [31:0] jump_addr,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        stall_req_if
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic STOP = 1'b1;

  localparam logic [31:0] PC_RESET = {PC_INIT[31:2], 2'b00};

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pending_pc;
  logic        discard;

  logic [31:0] flush_target;
  logic [31:0] jump_target;
  logic [31:0] pc_seq;
  logic        unused_inputs;

  // Redirect targets are word aligned; the low address bits are dropped.
  assign flush_target  = {flush_pc[31:2], 2'b00};
  assign jump_target   = {jump_addr[31:2], 2'b00};
  assign pc_seq        = pc + 32'd4;
  assign unused_inputs = ^{stall[3:1], flush_pc[1:0], jump_addr[1:0]};

  // The request is live for the whole FETCH state, so it can never be
  // withdrawn early, and the address simply follows the internal pc.
  assign inst_req     = (state == FETCH);
  assign inst_addr    = pc;
  assign stall_req_if = (state == FETCH) && !inst_ack;

  // Fetch sequencing: request, capture, hold, then advance or redirect.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state        <= IDLE;
      pc           <= PC_RESET;
      pending_pc   <= PC_RESET;
      discard      <= 1'b0;
      if_pc        <= PC_INIT;
      if_pc_plus_4 <= PC_INIT;
      if_inst      <= 32'd0;
      if_valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            pc <= flush_target;
          end
          state <= FETCH;
        end

        FETCH: begin
          if (inst_ack) begin
            if (discard || flush) begin
              // Data answers a request made before the flush: drop it and
              // refetch from the most recent flush target.
              pc      <= flush ? flush_target : pending_pc;
              discard <= 1'b0;
            end else begin
              if_inst      <= inst_rdata;
              if_pc        <= pc;
              if_pc_plus_4 <= pc_seq;
              if_valid     <= 1'b1;
              state        <= HOLD;
            end
          end else if (flush) begin
            // The SRAM still owes us a reply; remember where to go once it
            // arrives rather than abandoning the handshake.
            discard    <= 1'b1;
            pending_pc <= flush_target;
          end
        end

        HOLD: begin
          if (flush) begin
            pc       <= flush_target;
            if_valid <= 1'b0;
            state    <= FETCH;
          end else if (stall[0] != STOP) begin
            if_valid <= 1'b0;
            pc       <= jump_flag ? jump_target : pc_seq;
            state    <= FETCH;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized scoreboard bench for if_fetch_unit. The driver works one fetch
// transaction at a time, predicting the next fetch address from the
// architectural rules and queueing each instruction expected to reach IF/ID;
// an independent monitor pops and compares whenever if_valid rises.
module tb_if_fetch_unit;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        cpu_clk_50M;
  logic        cpu_rst_n;
  logic [3:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        stall_req_if;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } fetch_t;

  fetch_t      sb[$];
  fetch_t      cur;
  logic        prev_valid;
  logic [31:0] exp_addr;
  int          checks;
  int          errors;

  if_fetch_unit #(.PC_INIT(PC_INIT)) dut (
    .cpu_clk_50M  (cpu_clk_50M),
    .cpu_rst_n    (cpu_rst_n),
    .stall        (stall),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .jump_flag    (jump_flag),
    .jump_addr    (jump_addr),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_ack     (inst_ack),
    .inst_rdata   (inst_rdata),
    .if_pc        (if_pc),
    .if_pc_plus_4 (if_pc_plus_4),
    .if_inst      (if_inst),
    .if_valid     (if_valid),
    .stall_req_if (stall_req_if)
  );

  // 50 MHz clock.
  initial begin
    cpu_clk_50M = 1'b0;
    forever #10 cpu_clk_50M = ~cpu_clk_50M;
  end

  // Backstop so a wedged DUT can never hang the run.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Memory image seen by the fetch unit: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next falling edge, where inputs are driven.
  task automatic step();
    @(negedge cpu_clk_50M);
    #1;
  endtask

  // One fetch transaction: wait for the request, answer after lat idle
  // cycles (optionally flushed), then hold for hold_n stalled cycles and
  // consume it (or flush it out of HOLD).
  task automatic applyStimulus(input int lat, input int flush_at, input logic [31:0] f_pc,
                               input bit f_twice, input logic [31:0] rdata, input int hold_n,
                               input bit hold_flush, input bit jmp, input logic [31:0] j_addr);
    logic [31:0] last_target;
    logic [31:0] f_pc2;
    logic        do_flush;
    logic        ack;
    int          w;
    fetch_t      e;
    inst_ack  = 1'b0;
    flush     = 1'b0;
    jump_flag = 1'b0;
    stall     = 4'd0;
    #1;
    w = 0;
    while (!inst_req && w < 4) begin
      checkOutput("idle_stall_req", {31'd0, stall_req_if}, 32'd0);
      step();
      #1;
      w++;
    end
    if (!inst_req) begin
      checkOutput("req_timeout", {31'd0, inst_req}, 32'd1);
      return;
    end
    checkOutput("req_addr", inst_addr, exp_addr);
    f_pc2       = f_pc ^ 32'h0000_0140;
    last_target = 32'd0;
    for (int c = 0; c <= lat; c++) begin
      ack        = (c == lat);
      do_flush   = (c == flush_at) || (f_twice && flush_at >= 0 && c > flush_at && c == lat);
      inst_ack   = ack;
      inst_rdata = ack ? rdata : $urandom;
      flush      = do_flush;
      flush_pc   = (c == flush_at) ? f_pc : f_pc2;
      jump_flag  = 1'($urandom_range(0, 1));
      jump_addr  = $urandom;
      stall      = {3'($urandom_range(0, 7)), 1'b0};
      if (do_flush) last_target = flush_pc;
      #1;
      checkOutput("fetch_req", {31'd0, inst_req}, 32'd1);
      checkOutput("fetch_addr", inst_addr, exp_addr);
      checkOutput("fetch_stall_req", {31'd0, stall_req_if}, {31'd0, !ack});
      checkOutput("fetch_valid", {31'd0, if_valid}, 32'd0);
      if (ack && flush_at < 0) begin
        e.pc   = exp_addr;
        e.pc4  = exp_addr + 32'd4;
        e.inst = rdata;
        sb.push_back(e);
      end
      step();
    end
    inst_ack = 1'b0;
    flush    = 1'b0;
    if (flush_at >= 0) begin
      exp_addr = {last_target[31:2], 2'b00};
      return;
    end
    for (int h = 0; h < hold_n; h++) begin
      stall     = {3'($urandom_range(0, 7)), 1'b1};
      jump_flag = 1'($urandom_range(0, 1));
      jump_addr = $urandom;
      #1;
      checkOutput("hold_req", {31'd0, inst_req}, 32'd0);
      checkOutput("hold_stall_req", {31'd0, stall_req_if}, 32'd0);
      checkOutput("hold_valid", {31'd0, if_valid}, 32'd1);
      step();
    end
    if (hold_flush) begin
      flush     = 1'b1;
      flush_pc  = f_pc;
      stall     = 4'($urandom_range(0, 15));
      jump_flag = 1'($urandom_range(0, 1));
      jump_addr = $urandom;
      exp_addr  = {f_pc[31:2], 2'b00};
    end else begin
      stall     = {3'($urandom_range(0, 7)), 1'b0};
      jump_flag = jmp;
      jump_addr = j_addr;
      exp_addr  = jmp ? {j_addr[31:2], 2'b00} : exp_addr + 32'd4;
    end
    #1;
    checkOutput("consume_valid", {31'd0, if_valid}, 32'd1);
    step();
    flush     = 1'b0;
    jump_flag = 1'b0;
  endtask

  // Monitor: every new instruction handed to IF/ID must match the head of
  // the scoreboard, and must stay put while it is being held.
  initial begin
    prev_valid = 1'b0;
    forever begin
      @(posedge cpu_clk_50M);
      #1;
      if (if_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
          checkOutput("if_pc", if_pc, cur.pc);
          checkOutput("if_pc_plus_4", if_pc_plus_4, cur.pc4);
          checkOutput("if_inst", if_inst, cur.inst);
        end
      end else if (if_valid) begin
        checkOutput("hold_if_pc", if_pc, cur.pc);
        checkOutput("hold_if_inst", if_inst, cur.inst);
      end
      prev_valid = if_valid;
    end
  end

  // Main sequence: reset, directed corner cases, random traffic, reset
  // during a fetch, and a final drain check.
  initial begin
    checks     = 0;
    errors     = 0;
    cpu_rst_n  = 1'b0;
    stall      = 4'd0;
    flush      = 1'b0;
    flush_pc   = 32'd0;
    jump_flag  = 1'b0;
    jump_addr  = 32'd0;
    inst_ack   = 1'b0;
    inst_rdata = 32'd0;
    exp_addr   = PC_INIT;
    repeat (3) step();
    checkOutput("rst_inst_req", {31'd0, inst_req}, 32'd0);
    checkOutput("rst_inst_addr", inst_addr, PC_INIT);
    checkOutput("rst_if_pc", if_pc, PC_INIT);
    checkOutput("rst_if_pc_plus_4", if_pc_plus_4, PC_INIT);
    checkOutput("rst_if_inst", if_inst, 32'd0);
    checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_stall_req", {31'd0, stall_req_if}, 32'd0);
    cpu_rst_n = 1'b1;

    $display("[TB] directed: first fetch, stall, jump, flush, wrap");
    applyStimulus(2, -1, 32'd0, 1'b0, 32'h2401_0001, 0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1, -1, 32'd0, 1'b0, mem_word(exp_addr), 3, 1'b0, 1'b0, 32'd0);
    applyStimulus(0, -1, 32'd0, 1'b0, mem_word(exp_addr), 1, 1'b0, 1'b1, 32'h0000_0100);
    applyStimulus(2, 0, 32'h0000_0380, 1'b0, mem_word(exp_addr), 0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1, -1, 32'hFFFF_FFFC, 1'b0, mem_word(exp_addr), 2, 1'b1, 1'b0, 32'd0);
    applyStimulus(1, -1, 32'd0, 1'b0, mem_word(exp_addr), 0, 1'b0, 1'b0, 32'd0);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      int lat;
      int fat;
      lat = $urandom_range(0, 3);
      fat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat)) : -1;
      applyStimulus(lat, fat, $urandom, 1'($urandom_range(0, 1)), mem_word(exp_addr),
                    $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 2) == 0), $urandom);
    end

    $display("[TB] reset during an outstanding fetch");
    #1;
    checkOutput("pre_reset_req", {31'd0, inst_req}, 32'd1);
    #3;
    cpu_rst_n  = 1'b0;
    inst_ack   = 1'b1;
    inst_rdata = 32'hDEAD_BEEF;
    #1;
    checkOutput("async_rst_req", {31'd0, inst_req}, 32'd0);
    checkOutput("async_rst_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("async_rst_addr", inst_addr, PC_INIT);
    checkOutput("async_rst_stall_req", {31'd0, stall_req_if}, 32'd0);
    repeat (2) step();
    inst_ack  = 1'b0;
    cpu_rst_n = 1'b1;
    exp_addr  = PC_INIT;
    applyStimulus(1, -1, 32'd0, 1'b0, mem_word(exp_addr), 1, 1'b0, 1'b0, 32'd0);
    applyStimulus(0, -1, 32'd0, 1'b0, mem_word(exp_addr), 0, 1'b0, 1'b0, 32'd0);

    repeat (3) step();
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
